// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Frame: 16-bit little-endian word count, then four little-endian bytes per word.
package imem_loader_pkg;

  localparam int unsigned MEM_WORDS_DEF  = 1024;
  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD;
  localparam int unsigned LEN_W          = BYTE_W * HDR_BYTES;
  localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  // Assemble the word count from its two header bytes.
  function automatic logic [LEN_W-1:0] hdr_len(input logic [BYTE_W-1:0] hi,
                                               input logic [BYTE_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits [8k+7:8k].
// full marks a completed word; last_c flags that the next load completes one.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              clear,
  input  logic [BYTE_W-1:0] data,
  output logic [WORD_W-1:0] word,
  output logic              full,
  output logic              last_c
);

  logic [BCNT_W-1:0] cnt;

  assign last_c = (cnt == BCNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      word <= '0;
      full <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      word <= '0;
      full <= 1'b0;
    end else if (load) begin
      for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
        if (cnt == BCNT_W'(k)) word[k*BYTE_W +: BYTE_W] <= data;
      end
      cnt  <= cnt + BCNT_W'(1);
      full <= last_c;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: turns a framed byte stream into instruction-memory word writes
// and holds the CPU until a complete image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
  parameter int unsigned ADDR_W    = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  state_t            state;
  state_t            next_state;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  hdr_len_c;
  logic              hs_c;
  logic              start_ok_c;
  logic              last_word_c;
  logic              pk_load_c;
  logic              pk_clear_c;
  logic              pk_full;
  logic              pk_last_c;
  logic              rx_ready_d;
  logic              mem_we_d;
  logic              cpu_hold_d;
  logic              done_d;
  logic              error_d;

  assign hs_c        = rx_valid && rx_ready;
  assign start_ok_c  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign hdr_len_c   = hdr_len(rx_data, len[BYTE_W-1:0]);
  assign last_word_c = (32'(mem_addr) + 32'd1 == 32'(len));
  assign pk_load_c   = hs_c && (state == S_DATA);
  assign pk_clear_c  = start_ok_c || (state == S_WRITE);

  byte_packer u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (pk_load_c),
    .clear   (pk_clear_c),
    .data    (rx_data),
    .word    (mem_wdata),
    .full    (pk_full),
    .last_c  (pk_last_c)
  );

  // State register; outputs are registered from the next-state decode so they
  // line up with the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      rx_ready <= 1'b0;
      mem_we   <= 1'b0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= next_state;
      rx_ready <= rx_ready_d;
      mem_we   <= mem_we_d;
      cpu_hold <= cpu_hold_d;
      done     <= done_d;
      error    <= error_d;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) next_state = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (hs_c) next_state = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (hs_c) begin
          if (hdr_len_c == '0)                   next_state = S_DONE;
          else if (32'(hdr_len_c) > MEM_WORDS)   next_state = S_ERR;
          else                                   next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (hs_c && pk_last_c) next_state = S_WRITE;
      end
      S_WRITE: begin
        if (pk_full) next_state = last_word_c ? S_DONE : S_DATA;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state.
  always_comb begin
    rx_ready_d = 1'b0;
    mem_we_d   = 1'b0;
    cpu_hold_d = 1'b1;
    done_d     = 1'b0;
    error_d    = 1'b0;
    case (next_state)
      S_LEN_LO, S_LEN_HI, S_DATA: rx_ready_d = 1'b1;
      S_WRITE:                    mem_we_d   = 1'b1;
      S_DONE: begin
        done_d     = 1'b1;
        cpu_hold_d = 1'b0;
      end
      S_ERR:                      error_d    = 1'b1;
      default: ;
    endcase
  end

  // Length register and word address; the address stops at the last word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len      <= '0;
      mem_addr <= '0;
    end else begin
      if (hs_c && state == S_LEN_LO) len[BYTE_W-1:0]     <= rx_data;
      if (hs_c && state == S_LEN_HI) len[LEN_W-1:BYTE_W] <= rx_data;
      if (start_ok_c)
        mem_addr <= '0;
      else if (state == S_WRITE && next_state == S_DATA)
        mem_addr <= mem_addr + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader with a byte-level frame model.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  imem_loader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          hs_cyc_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] exp_word[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe writes and handshakes mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(int'(mem_addr));
      wr_data_q.push_back(mem_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (rx_valid && rx_ready) hs_cyc_q.push_back(cyc);
  end

  task automatic clear_capture();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); hs_cyc_q.delete();
  endtask

  // Reference frame: header + random bytes; expected words built arithmetically.
  task automatic build_frame(input int unsigned n);
    logic [7:0] b [4];
    logic [31:0] w;
    tx_q.delete(); exp_word.delete();
    tx_q.push_back(8'(n & 32'hff));
    tx_q.push_back(8'((n >> 8) & 32'hff));
    if (n <= 1024) begin
      for (int unsigned i = 0; i < n; i++) begin
        for (int k = 0; k < 4; k++) begin
          b[k] = 8'($urandom_range(0, 255));
          tx_q.push_back(b[k]);
        end
        w = 32'd0;
        for (int k = 3; k >= 0; k--) w = w * 32'd256 + 32'(b[k]);
        exp_word.push_back(w);
      end
    end
  endtask

  // Write-stream disagreements against the model (address, data, 1-cycle latency).
  function automatic int count_write_errors(input int n);
    int e = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= wr_addr_q.size()) begin
        e++;
      end else begin
        if (wr_addr_q[i] != i) e++;
        if (wr_data_q[i] !== exp_word[i]) e++;
        if (2 + 4*i + 3 >= hs_cyc_q.size()) e++;
        else if (wr_cyc_q[i] != hs_cyc_q[2 + 4*i + 3] + 1) e++;
      end
    end
    return e;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_frame(input int gap, input bit chk, input int limit,
                            output int bad, output bit ok);
    bit acc;
    int last;
    bad = 0; ok = 1'b1;
    last = tx_q.size() - 1;
    for (int i = 0; i < tx_q.size() && i < limit; i++) begin
      rx_data = tx_q[i]; rx_valid = 1'b1; acc = 1'b0;
      for (int t = 0; t < 64 && !acc; t++) begin
        @(negedge clk);
        if (rx_ready) acc = 1'b1;
        @(posedge clk); #1;
      end
      rx_valid = 1'b0;
      if (!acc) begin ok = 1'b0; break; end
      if (i != last) begin
        repeat (gap) begin
          @(negedge clk);
          if (chk && rx_ready !== 1'b1) bad++;
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic wait_end(input int budget, output bit hit);
    hit = 1'b0;
    for (int t = 0; t < budget && !hit; t++) begin
      @(negedge clk);
      if (done || error) hit = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checks++; if (rx_ready !== 1'b0)  $display("FAIL reset_rx_ready: got %b want 0", rx_ready);   else passes++;
    checks++; if (mem_we !== 1'b0)    $display("FAIL reset_mem_we: got %b want 0", mem_we);       else passes++;
    checks++; if (mem_addr !== '0)    $display("FAIL reset_mem_addr: got %0d want 0", mem_addr);  else passes++;
    checks++; if (mem_wdata !== '0)   $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); else passes++;
    checks++; if (cpu_hold !== 1'b1)  $display("FAIL reset_cpu_hold: got %b want 1", cpu_hold);   else passes++;
    checks++; if (done !== 1'b0)      $display("FAIL reset_done: got %b want 0", done);           else passes++;
    checks++; if (error !== 1'b0)     $display("FAIL reset_error: got %b want 0", error);         else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int bad; bit ok, hit;
    clear_capture();
    do_start();
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    exp_word = '{32'h00100513, 32'h00200593};
    send_frame(0, 1'b0, 1 << 20, bad, ok);
    wait_end(50, hit);
    checks++; if (!(ok && hit)) $display("FAIL basic_timeout: ok=%b hit=%b want 1 1", ok, hit); else passes++;
    checks++; if (wr_addr_q.size() != 2) $display("FAIL basic_count: got %0d want 2", wr_addr_q.size()); else passes++;
    checks++; if ((wr_data_q.size() > 0 ? wr_data_q[0] : 32'hx) !== 32'h00100513)
                $display("FAIL basic_word0: got %h want 00100513", wr_data_q.size() > 0 ? wr_data_q[0] : 32'hx); else passes++;
    checks++; if ((wr_data_q.size() > 1 ? wr_data_q[1] : 32'hx) !== 32'h00200593)
                $display("FAIL basic_word1: got %h want 00200593", wr_data_q.size() > 1 ? wr_data_q[1] : 32'hx); else passes++;
    checks++; if (count_write_errors(2) != 0) $display("FAIL basic_addr_latency: got %0d errors want 0", count_write_errors(2)); else passes++;
    checks++; if ({done, cpu_hold, error, rx_ready} !== 4'b1000)
                $display("FAIL basic_final: got done/hold/err/ready=%b want 1000", {done, cpu_hold, error, rx_ready}); else passes++;
  endtask

  task automatic test_zero();
    int bad; bit ok, hit;
    do_start();
    clear_capture();
    build_frame(0);
    send_frame(0, 1'b0, 1 << 20, bad, ok);
    wait_end(20, hit);
    checks++; if (!(ok && hit)) $display("FAIL zero_timeout: ok=%b hit=%b want 1 1", ok, hit); else passes++;
    checks++; if (wr_addr_q.size() != 0) $display("FAIL zero_writes: got %0d want 0", wr_addr_q.size()); else passes++;
    checks++; if ({done, cpu_hold, error} !== 3'b100)
                $display("FAIL zero_final: got done/hold/err=%b want 100", {done, cpu_hold, error}); else passes++;
  endtask

  task automatic test_oversize();
    int bad, n; bit ok, hit;
    for (int r = 0; r < 3; r++) begin
      do_start();
      clear_capture();
      build_frame(r == 0 ? 1025 : $urandom_range(1025, 65535));
      send_frame(0, 1'b0, 1 << 20, bad, ok);
      wait_end(20, hit);
      checks++; if (!(ok && hit)) $display("FAIL over_timeout: ok=%b hit=%b want 1 1", ok, hit); else passes++;
      checks++; if ({error, cpu_hold, done} !== 3'b110)
                  $display("FAIL over_state: got err/hold/done=%b want 110", {error, cpu_hold, done}); else passes++;
      checks++; if (wr_addr_q.size() != 0) $display("FAIL over_writes: got %0d want 0", wr_addr_q.size()); else passes++;
    end
    do_start();
    checks++; if ({error, cpu_hold, done, rx_ready} !== 4'b0101)
                $display("FAIL over_restart: got err/hold/done/ready=%b want 0101", {error, cpu_hold, done, rx_ready}); else passes++;
    clear_capture();
    n = $urandom_range(1, 4);
    build_frame(n);
    send_frame(0, 1'b0, 1 << 20, bad, ok);
    wait_end(50, hit);
    checks++; if (!(ok && hit) || {done, error} !== 2'b10)
                $display("FAIL over_recover: ok=%b hit=%b done/err=%b want 1 1 10", ok, hit, {done, error}); else passes++;
    checks++; if (wr_addr_q.size() != n || count_write_errors(n) != 0)
                $display("FAIL over_recover_writes: got %0d writes %0d errors want %0d 0", wr_addr_q.size(), count_write_errors(n), n); else passes++;
  endtask

  task automatic test_gap();
    int bad, hs_before; bit ok;
    do_start();
    clear_capture();
    build_frame(1);
    send_frame(3, 1'b1, 1 << 20, bad, ok);
    checks++; if (!ok || bad != 0) $display("FAIL gap_ready: ok=%b low-ready gap cycles=%0d want 1 0", ok, bad); else passes++;
    checks++; if ({mem_we, rx_ready} !== 2'b10)
                $display("FAIL gap_write_cycle: got we/ready=%b want 10", {mem_we, rx_ready}); else passes++;
    @(posedge clk); #1;
    checks++; if ({mem_we, rx_ready, done} !== 3'b001)
                $display("FAIL gap_done_cycle: got we/ready/done=%b want 001", {mem_we, rx_ready, done}); else passes++;
    hs_before = hs_cyc_q.size();
    rx_data = 8'hA5; rx_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 rx_valid = 1'b0;
    checks++; if (hs_cyc_q.size() != hs_before) $display("FAIL gap_done_consumed: got %0d handshakes want %0d", hs_cyc_q.size(), hs_before); else passes++;
    checks++; if (wr_addr_q.size() != 1 || count_write_errors(1) != 0)
                $display("FAIL gap_writes: got %0d writes %0d errors want 1 0", wr_addr_q.size(), count_write_errors(1)); else passes++;
  endtask

  task automatic test_random();
    int bad, n, g; bit ok, hit;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 6);
      g = $urandom_range(0, 2);
      do_start();
      clear_capture();
      build_frame(n);
      send_frame(g, 1'b0, 1 << 20, bad, ok);
      wait_end(50, hit);
      checks++; if (!(ok && hit) || done !== 1'b1)
                  $display("FAIL rand_done: n=%0d ok=%b hit=%b done=%b want 1 1 1", n, ok, hit, done); else passes++;
      checks++; if (wr_addr_q.size() != n || count_write_errors(n) != 0)
                  $display("FAIL rand_writes: n=%0d got %0d writes %0d errors want %0d 0", n, wr_addr_q.size(), count_write_errors(n), n); else passes++;
    end
  endtask

  task automatic test_reset_mid();
    int bad; bit ok, hit;
    do_start();
    clear_capture();
    build_frame(3);
    send_frame(0, 1'b0, 7, bad, ok);
    reset_n = 1'b0;
    #2;
    checks++; if (!ok || wr_addr_q.size() != 1) $display("FAIL mid_partial: ok=%b got %0d writes want 1 1", ok, wr_addr_q.size()); else passes++;
    checks++; if ({rx_ready, mem_we, cpu_hold, done, error} !== 5'b00100)
                $display("FAIL mid_reset_ctrl: got ready/we/hold/done/err=%b want 00100", {rx_ready, mem_we, cpu_hold, done, error}); else passes++;
    checks++; if (mem_addr !== '0 || mem_wdata !== '0)
                $display("FAIL mid_reset_bus: got addr=%0d data=%h want 0 0", mem_addr, mem_wdata); else passes++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_start();
    clear_capture();
    build_frame(2);
    send_frame(0, 1'b0, 1 << 20, bad, ok);
    wait_end(50, hit);
    checks++; if (!(ok && hit) || wr_addr_q.size() != 2 || count_write_errors(2) != 0)
                $display("FAIL mid_restart: ok=%b hit=%b got %0d writes %0d errors want 1 1 2 0", ok, hit, wr_addr_q.size(), count_write_errors(2)); else passes++;
  endtask

  task automatic test_full_depth();
    int bad; bit ok, hit;
    do_start();
    clear_capture();
    build_frame(1024);
    send_frame(0, 1'b0, 1 << 20, bad, ok);
    wait_end(50, hit);
    checks++; if (!(ok && hit) || {done, cpu_hold} !== 2'b10)
                $display("FAIL full_done: ok=%b hit=%b done/hold=%b want 1 1 10", ok, hit, {done, cpu_hold}); else passes++;
    checks++; if (wr_addr_q.size() != 1024) $display("FAIL full_count: got %0d want 1024", wr_addr_q.size()); else passes++;
    checks++; if ((wr_addr_q.size() > 0 ? wr_addr_q[wr_addr_q.size()-1] : -1) != 1023)
                $display("FAIL full_last_addr: got %0d want 1023", wr_addr_q.size() > 0 ? wr_addr_q[wr_addr_q.size()-1] : -1); else passes++;
    checks++; if (count_write_errors(1024) != 0) $display("FAIL full_writes: got %0d errors want 0", count_write_errors(1024)); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_oversize();
    test_gap();
    test_random();
    test_reset_mid();
    test_full_depth();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the 1024x32 instruction memory (4 KB, word-addressed, little-endian words): consumes a framed byte stream from the SoC's serial/debug byte channel and produces word write strobes on the instruction memory write port.
- Holds the CPU core stalled until a complete program image has been written, then releases it.
- Sits between the byte-stream source (valid/ready) and the instruction memory write port.

Parameters:
- MEM_WORDS, 1024, instruction memory depth in 32-bit words
- ADDR_W, 10, word-address width; must equal clog2(MEM_WORDS)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; arms a new load from IDLE, DONE or ERR
- rx_data  in  8  incoming stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte; a byte transfers when rx_valid && rx_ready
- mem_we  out  1  instruction memory write strobe, one cycle per word
- mem_addr  out  ADDR_W  word address (byte address = mem_addr*4)
- mem_wdata  out  32  instruction word
- cpu_hold  out  1  holds the core's PC and fetch while high
- done  out  1  load completed successfully
- error  out  1  header length illegal

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset values: state=IDLE, rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0. Byte count and word count clear to 0.
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N*4 data bytes. Byte k of each word lands at mem_wdata[8k+7:8k].
- IDLE:
  - rx_ready=0, cpu_hold=1.
  - start goes to LEN_LO and clears mem_addr.
- LEN_LO: rx_ready=1. On handshake, latch N[7:0] and go to LEN_HI.
- LEN_HI: rx_ready=1. On handshake, latch N[15:8], then evaluate N next cycle (registered decision):
  - N=0 goes to DONE.
  - N>MEM_WORDS goes to ERR.
  - Otherwise go to DATA.
- DATA:
  - rx_ready=1.
  - Each handshake shifts the byte into the packer and increments the 2-bit byte count.
  - The 4th handshake goes to WRITE.
  - Cycles with rx_valid=0 insert gaps and change no state.
- WRITE:
  - rx_ready=0. mem_we=1 for exactly this cycle, with mem_wdata set to the packed word and mem_addr set to the current word index.
  - Latency from the 4th byte handshake to mem_we is 1 cycle.
  - Next cycle mem_addr increments. If mem_addr==N-1, go to DONE; otherwise go to DATA.
- DONE:
  - done=1, cpu_hold=0, rx_ready=0.
  - Stream bytes are not consumed; rx_ready stays 0 until restart.
- ERR: error=1, cpu_hold=1, rx_ready=0.
- start handling:
  - In DONE or ERR, start clears done/error, asserts cpu_hold and goes to LEN_LO on the next cycle.
  - start is ignored in LEN_LO, LEN_HI, DATA and WRITE.
- Wrap: mem_addr never wraps. N<=MEM_WORDS guarantees the last address is MEM_WORDS-1 at most.
- Reset mid-load: all state returns to reset values immediately. Words already written stay in memory, and cpu_hold stays 1.
- Simultaneous events: rx_valid during WRITE is held off by rx_ready=0, so no byte is lost.

Decomposition:
- Shared package imem_loader_pkg:
  - state encoding (IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR)
  - HDR_BYTES=2
  - BYTES_PER_WORD=4
- Sub-module byte_packer: 4x8-bit little-endian shift/assemble register with byte counter, load enable and clear. Outputs word[31:0] and full.
- Top level holds the FSM, the length register and the address counter.

Test Plan:
- Basic load: start, bytes 02 00 13 05 10 00 93 05 20 00 -> mem_we at addr 0 with 0x00100513, then at addr 1 with 0x00200593; done=1, cpu_hold=0; each mem_we exactly 1 cycle after its 4th byte.
- Zero length: start, bytes 00 00 -> no mem_we; done=1, cpu_hold falls.
- Oversize length: start, bytes 01 04 (N=1025) -> error=1, cpu_hold=1, no mem_we; a following start plus valid frame -> done=1, error=0.
- Gapped stream: 1-word frame with rx_valid low for 3 cycles between each byte -> single mem_we at addr 0 with the correct word; rx_ready=0 only in IDLE, WRITE and DONE.
- Reset mid-load: assert reset_n=0 after 5 data bytes of a 3-word frame -> immediately all outputs at reset values (cpu_hold=1); a new start with a full frame -> addresses restart at 0.
- Full depth: N=1024, random data -> 1024 writes, last at addr 1023; done=1 and no address wrap.
